// File: rtl/alu16_rr_sched_if.sv
// rtl/alu16_rr_sched_if.sv - request/response bundle between requesters and alu16_rr_sched
// Purpose: groups the per-requester request handshake and the shared result
//          handshake into one bundle.
// Signals:
//   req_valid [NREQ]     per-requester request valid
//   req_a     [16*NREQ]  operand A, requester i at [16i+15:16i]
//   req_b     [16*NREQ]  operand B, same packing
//   req_op    [4*NREQ]   ALU opcode, requester i at [4i+3:4i]
//   req_ready [NREQ]     one-hot grant/accept from the scheduler
//   rsp_valid            result valid
//   rsp_ready            result consumed
//   rsp_y     [16]       registered ALU result
//   rsp_carry            registered ALU carry
//   rsp_id    [IDW]      index of the requester that issued the result
// Modports: master = requester/consumer side, slave = scheduler side.
interface alu16_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [4*NREQ-1:0]  req_op;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [15:0]        rsp_y;
  logic               rsp_carry;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_id
  );
endinterface

// File: rtl/alu16_rr_sched.sv
// rtl/alu16_rr_sched.sv - round-robin scheduler sharing one 16-bit CLA ALU among NREQ requesters
// Purpose: serialises requests from NREQ requesters onto one alu16_cla, returning a
//          registered result tagged with the requester index.
// Optional feature macro: ALU16_SCHED_STATS_EN (result toggle / op counters).
// alu16_cla ports:
//   a, b [16] operands; s [4] opcode; yout [16] result; carry carry/shift-out
// alu16_rr_sched ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   bus           alu16_rr_sched_if.slave request/response bundle
//   busy          high while a transaction is in flight
//   stats_clr     clears activity counters (feature builds only)
//   toggle_count  accumulated result-bit toggles (0 when feature absent)
//   op_count      completed operations (0 when feature absent)

module alu16_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  output logic [15:0] yout,
  output logic        carry
);
  logic [15:0] x, y, p, g, sum;
  logic        cin;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic [16:0] c;

  // Adder operand selection: subtract forms use x + ~y + 1.
  always_comb begin
    x   = a;
    y   = b;
    cin = 1'b0;
    case (s)
      4'd1:    begin y = ~b; cin = 1'b1; end
      4'd8:    begin y = 16'h0000; cin = 1'b1; end
      4'd9:    y = 16'hFFFF;
      4'd10:   begin x = b; y = ~a; cin = 1'b1; end
      default: ;
    endcase
  end

  assign p = x ^ y;
  assign g = x & y;

  // Two-level lookahead: 4-bit group generate/propagate feed the group carries,
  // which then seed short ripples inside each group.
  always_comb begin
    gg    = '0;
    gp    = '0;
    gc    = '0;
    c     = '0;
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = gc[4];
  end

  assign sum = p ^ c[15:0];

  always_comb begin
    yout  = 16'h0000;
    carry = 1'b0;
    case (s)
      4'd0, 4'd1, 4'd8, 4'd9, 4'd10: begin yout = sum; carry = c[16]; end
      4'd2:  yout = a & b;
      4'd3:  yout = a | b;
      4'd4:  yout = a ^ b;
      4'd5:  yout = ~(a | b);
      4'd6:  yout = ~(a & b);
      4'd7:  yout = ~a;
      4'd11: begin yout = {a[14:0], 1'b0}; carry = a[15]; end
      4'd12: begin yout = {1'b0, a[15:1]}; carry = a[0]; end
      4'd13: yout = a;
      4'd14: yout = b;
      default: ;
    endcase
  end
endmodule

module alu16_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu16_rr_sched_if.slave       bus,
  output logic                  busy,
  input  logic                  stats_clr,
  output logic [31:0]           toggle_count,
  output logic [31:0]           op_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]     op_s_q, op_s_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    rsp_y_q, rsp_y_d;
  logic           rsp_c_q, rsp_c_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic [15:0]    alu_y;
  logic           alu_c;

  alu16_cla u_alu (
    .a     (op_a_q),
    .b     (op_b_q),
    .s     (op_s_q),
    .yout  (alu_y),
    .carry (alu_c)
  );

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && grant_found && !rst) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_s_d      = op_s_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op_a_d   = bus.req_a[16*grant_idx +: 16];
          op_b_d   = bus.req_b[16*grant_idx +: 16];
          op_s_d   = bus.req_op[4*grant_idx +: 4];
          op_id_d  = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_y_d     = alu_y;
        rsp_c_d     = alu_c;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_s_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_s_q      <= op_s_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_carry = rsp_c_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != S_IDLE) && !rst;

`ifdef ALU16_SCHED_STATS_EN
  logic [31:0] tog_q, tog_d, opc_q, opc_d;
  logic [15:0] prev_y_q, prev_y_d;
  logic [4:0]  flips;
  logic [32:0] tog_sum;

  // Clear outranks same-cycle increments; both counters stick at all-ones.
  always_comb begin
    flips    = 5'($countones(alu_y ^ prev_y_q));
    tog_sum  = {1'b0, tog_q} + {28'b0, flips};
    tog_d    = tog_q;
    opc_d    = opc_q;
    prev_y_d = prev_y_q;
    if (stats_clr) begin
      tog_d    = '0;
      opc_d    = '0;
      prev_y_d = '0;
    end else begin
      if (state_q == S_EXEC) begin
        tog_d    = tog_sum[32] ? 32'hFFFF_FFFF : tog_sum[31:0];
        prev_y_d = alu_y;
      end
      if (state_q == S_RESP && bus.rsp_ready && opc_q != 32'hFFFF_FFFF) opc_d = opc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q    <= '0;
      opc_q    <= '0;
      prev_y_q <= '0;
    end else begin
      tog_q    <= tog_d;
      opc_q    <= opc_d;
      prev_y_q <= prev_y_d;
    end
  end

  assign toggle_count = tog_q;
  assign op_count     = opc_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign toggle_count     = '0;
  assign op_count         = '0;
`endif
endmodule

// File: tb/tb_alu16_rr_sched.sv
// tb/tb_alu16_rr_sched.sv - self-checking bench for alu16_rr_sched
module tb_alu16_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        stats_clr;
  logic [31:0] toggle_count;
  logic [31:0] op_count;

  logic [15:0]     av  [NREQ];
  logic [15:0]     bv  [NREQ];
  logic [3:0]      opv [NREQ];
  logic [NREQ-1:0] vld;
  logic            rdy;

  logic [15:0] ref_a, ref_b, ref_y;
  logic [3:0]  ref_s;
  logic        ref_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [IDW+16:0] sb [$];
  logic [IDW+16:0] exp_e, got_e;
  logic [16:0]     mr;
  int              gi;

  always #5 clk = ~clk;

  alu16_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu16_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .stats_clr    (stats_clr),
    .toggle_count (toggle_count),
    .op_count     (op_count)
  );

  alu16_cla u_ref (
    .a     (ref_a),
    .b     (ref_b),
    .s     (ref_s),
    .yout  (ref_y),
    .carry (ref_c)
  );

  always_comb begin
    bus.req_a  = '0;
    bus.req_b  = '0;
    bus.req_op = '0;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_a[16*k +: 16] = av[k];
      bus.req_b[16*k +: 16] = bv[k];
      bus.req_op[4*k +: 4]  = opv[k];
    end
    bus.req_valid = vld;
    bus.rsp_ready = rdy;
  end

  // Returns {carry, y}.
  function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s);
    logic [16:0] r;
    logic [15:0] nb, na;
    nb = ~b;
    na = ~a;
    case (s)
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {1'b0, a} + {1'b0, nb} + 17'd1;
      4'd2:  r = {1'b0, a & b};
      4'd3:  r = {1'b0, a | b};
      4'd4:  r = {1'b0, a ^ b};
      4'd5:  r = {1'b0, ~(a | b)};
      4'd6:  r = {1'b0, ~(a & b)};
      4'd7:  r = {1'b0, na};
      4'd8:  r = {1'b0, a} + 17'd1;
      4'd9:  r = {1'b0, a} + 17'h0FFFF;
      4'd10: r = {1'b0, b} + {1'b0, na} + 17'd1;
      4'd11: r = {a, 1'b0};
      4'd12: r = {a[0], 1'b0, a[15:1]};
      4'd13: r = {1'b0, a};
      4'd14: r = {1'b0, b};
      default: r = 17'd0;
    endcase
    return r;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Scoreboard: push on grant, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      total_cnt++;
      got_e = {bus.rsp_id, bus.rsp_carry, bus.rsp_y};
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got id/carry/y=%h, required no response", got_e);
      end else begin
        exp_e = sb.pop_front();
        if (got_e !== exp_e) $display("FAIL sb_result: got id/carry/y=%h, required %h", got_e, exp_e);
        else pass_cnt++;
      end
    end
    if (!rst && bus.req_ready != '0) begin
      gi = onehot_idx(bus.req_ready);
      mr = alu_model(av[gi], bv[gi], opv[gi]);
      sb.push_back({IDW'(gi), mr});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; rdy = 1'b1; stats_clr = 1'b0;
    for (int k = 0; k < NREQ; k++) begin av[k] = '0; bv[k] = '0; opv[k] = '0; end
    ref_a = 16'h1234; ref_b = 16'h00FF; ref_s = 4'd0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
    total_cnt++; if ({bus.rsp_id, bus.rsp_carry, bus.rsp_y} !== '0) $display("FAIL reset_rsp_fields: got %h, required 0", {bus.rsp_id, bus.rsp_carry, bus.rsp_y}); else pass_cnt++;
    total_cnt++; if ({toggle_count, op_count} !== 64'd0) $display("FAIL reset_counters: got %h, required 0", {toggle_count, op_count}); else pass_cnt++;
  endtask

  task automatic test_single();
    av[2] = 16'h1234; bv[2] = 16'h00FF; opv[2] = 4'd0; rdy = 1'b1; vld = 4'b0100;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: got %b, required 0100", bus.req_ready); else pass_cnt++;
    tick();
    vld = '0;
    total_cnt++; if ({bus.rsp_valid, busy} !== 2'b01) $display("FAIL single_exec: got valid/busy=%b, required 01", {bus.rsp_valid, busy}); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_latency: got rsp_valid=%b, required 1", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_id !== 2'd2) $display("FAIL single_id: got %0d, required 2", bus.rsp_id); else pass_cnt++;
    total_cnt++; if ({bus.rsp_carry, bus.rsp_y} !== {ref_c, ref_y}) $display("FAIL single_vs_ref: got %h, required %h", {bus.rsp_carry, bus.rsp_y}, {ref_c, ref_y}); else pass_cnt++;
    total_cnt++; if ({bus.rsp_carry, bus.rsp_y} !== 17'h01333) $display("FAIL single_value: got %h, required 01333", {bus.rsp_carry, bus.rsp_y}); else pass_cnt++;
    tick();
    total_cnt++; if ({bus.rsp_valid, busy} !== 2'b00) $display("FAIL single_done: got valid/busy=%b, required 00", {bus.rsp_valid, busy}); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int w;
    int g;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      av[k] = 16'($urandom); bv[k] = 16'($urandom); opv[k] = 4'($urandom);
    end
    rdy = 1'b1; vld = '1;
    #1;
    for (int n = 0; n < 12; n++) begin
      w = 0;
      while (bus.req_ready == '0 && w < 10) begin tick(); w++; end
      total_cnt++;
      if (bus.req_ready !== 4'(1 << (n % NREQ))) $display("FAIL rr_grant_%0d: got %b, required %b", n, bus.req_ready, 4'(1 << (n % NREQ)));
      else pass_cnt++;
      g = onehot_idx(bus.req_ready);
      tick();
      if (g >= 0) begin av[g] = 16'($urandom); bv[g] = 16'($urandom); opv[g] = 4'($urandom); end
    end
    vld = '0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [16+IDW:0] held;
    int w;
    rdy = 1'b0; vld = 4'b1000;
    av[3] = 16'hFFFF; bv[3] = 16'h0001; opv[3] = 4'd0;
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 10) begin tick(); w++; end
    tick();
    vld = 4'b0010;
    av[1] = 16'h00F0; bv[1] = 16'h0F0F; opv[1] = 4'd4;
    tick();
    held = {bus.rsp_id, bus.rsp_carry, bus.rsp_y};
    total_cnt++; if ({bus.rsp_valid, held} !== {1'b1, 2'd3, 17'h10000}) $display("FAIL bp_first: got %h, required %h", {bus.rsp_valid, held}, {1'b1, 2'd3, 17'h10000}); else pass_cnt++;
    for (int n = 0; n < 10; n++) begin
      tick();
      total_cnt++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_y, bus.req_ready} !== {1'b1, held, 4'b0000})
        $display("FAIL bp_hold_%0d: got %h, required %h", n, {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_y, bus.req_ready}, {1'b1, held, 4'b0000});
      else pass_cnt++;
    end
    rdy = 1'b1;
    tick();
    total_cnt++; if ({bus.rsp_valid, bus.req_ready} !== 5'b0_0010) $display("FAIL bp_release: got %b, required 00010", {bus.rsp_valid, bus.req_ready}); else pass_cnt++;
    vld = '0;
    #1;
  endtask

  task automatic test_reset_midflight();
    rdy = 1'b1; vld = 4'b0010;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL rst_exec_grant: got %b, required 0010", bus.req_ready); else pass_cnt++;
    tick();
    vld = '0; rst = 1'b1;
    #1;
    total_cnt++; if ({busy, bus.req_ready} !== 5'b0) $display("FAIL rst_exec_during: got busy/ready=%b, required 00000", {busy, bus.req_ready}); else pass_cnt++;
    tick();
    rst = 1'b0;
    total_cnt++; if ({bus.rsp_valid, busy} !== 2'b00) $display("FAIL rst_exec_after: got valid/busy=%b, required 00", {bus.rsp_valid, busy}); else pass_cnt++;
    vld = '1;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_exec_ptr: got %b, required 0001", bus.req_ready); else pass_cnt++;
    vld = '0;
    sb.delete();

    rdy = 1'b0; vld = 4'b0100; av[2] = 16'hABCD; bv[2] = 16'h1111; opv[2] = 4'd3;
    #1;
    tick();
    vld = '0;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL rst_resp_reach: got rsp_valid=%b, required 1", bus.rsp_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_resp_busy: got %b, required 0", busy); else pass_cnt++;
    tick();
    rst = 1'b0;
    total_cnt++; if ({bus.rsp_valid, busy, bus.rsp_y} !== 18'd0) $display("FAIL rst_resp_after: got %h, required 0", {bus.rsp_valid, busy, bus.rsp_y}); else pass_cnt++;
    vld = '1;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_resp_ptr: got %b, required 0001", bus.req_ready); else pass_cnt++;
    vld = '0;
    sb.delete();
    rdy = 1'b1;
    #1;
  endtask

`ifdef ALU16_SCHED_STATS_EN
  task automatic test_stats();
    logic [15:0] prev;
    logic [16:0] r;
    logic [31:0] tog;
    int          g;
    int          stalls;
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    total_cnt++; if ({toggle_count, op_count} !== 64'd0) $display("FAIL stats_clr_start: got %h, required 0", {toggle_count, op_count}); else pass_cnt++;
    prev = '0; tog = '0; stalls = 0; rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        av[k] = 16'($urandom); bv[k] = 16'($urandom); opv[k] = 4'($urandom);
      end
      vld = 4'($urandom_range(1, 15));
      #1;
      g = onehot_idx(bus.req_ready);
      if (g < 0) begin
        stalls++;
      end else begin
        r    = alu_model(av[g], bv[g], opv[g]);
        tog  = tog + 32'($countones(r[15:0] ^ prev));
        prev = r[15:0];
      end
      tick();
      vld = '0;
      tick(); tick();
    end
    total_cnt++; if (stalls !== 0) $display("FAIL stats_grants: got %0d idle-cycle misses, required 0", stalls); else pass_cnt++;
    total_cnt++; if (op_count !== 32'd1000) $display("FAIL stats_op_count: got %0d, required 1000", op_count); else pass_cnt++;
    total_cnt++; if (toggle_count !== tog) $display("FAIL stats_toggle_count: got %0d, required %0d", toggle_count, tog); else pass_cnt++;
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    total_cnt++; if ({toggle_count, op_count} !== 64'd0) $display("FAIL stats_clr_end: got %h, required 0", {toggle_count, op_count}); else pass_cnt++;
  endtask
`else
  task automatic test_counters_off();
    stats_clr = 1'b1; tick(); stats_clr = 1'b0; tick();
    total_cnt++; if ({toggle_count, op_count} !== 64'd0) $display("FAIL counters_off: got %h, required 0", {toggle_count, op_count}); else pass_cnt++;
  endtask
`endif

  task automatic test_drain();
    repeat (4) tick();
    total_cnt++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending results, required 0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
`ifdef ALU16_SCHED_STATS_EN
    test_stats();
`else
    test_counters_off();
`endif
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu16_rr_sched.md
Name: alu16_rr_sched

Overview:
- Round-robin scheduler that shares one 16-bit ALU datapath (alu16_cla, ports a/b/s/yout/carry) among NREQ independent requesters.
- Each requester offers operands plus a 4-bit opcode through a valid/ready handshake.
- The block serialises requests, drives the ALU from registered operands and returns a registered result tagged with the requester index.
- Optionally accumulates output-bit toggle activity, for the power/activity characterisation flow.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  16*NREQ  operand A, requester i at bits [16i+15:16i].
- req_b  input  16*NREQ  operand B, same packing.
- req_op  input  4*NREQ  ALU opcode s, requester i at [4i+3:4i].
- req_ready  output  NREQ  one-hot grant/accept; at most one bit set.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumed.
- rsp_y  output  16  registered ALU yout.
- rsp_carry  output  1  registered ALU carry.
- rsp_id  output  IDW  index of requester that issued this result.
- busy  output  1  high whenever state != IDLE.
- stats_clr  input  1  clears activity counters (feature only; ignored otherwise).
- toggle_count  output  32  accumulated yout toggles (feature only; else tied 0).
- op_count  output  32  completed operations (feature only; else tied 0).

Behaviour:
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE arbitration:
  - req_ready = one-hot grant to the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  - Grant is combinational from req_valid and rr_ptr, and is asserted only in IDLE.
- Accept (IDLE with any req_valid):
  - Latch a, b, op and id of the granted requester into op registers.
  - rr_ptr <= (granted index + 1) mod NREQ.
  - Go to EXEC.
- IDLE with no req_valid: stay; req_ready = 0.
- EXEC (one cycle):
  - ALU combinationally evaluates the op registers.
  - rsp_y <= yout, rsp_carry <= carry, rsp_id <= latched id, rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - req_ready = 0 in EXEC and RESP; no new acceptance until back in IDLE.
- Latency and throughput:
  - Accept edge N -> rsp_valid high in cycle N+2.
  - Best-case throughput is 1 op per 3 cycles.
- Requester contract: req fields must stay stable while req_valid is high and not accepted. Dropping req_valid before grant is legal and that request is lost.
- Reset (rst high at clock edge, from any state, including mid-EXEC/RESP):
  - state = IDLE, rr_ptr = 0.
  - Op registers = 0; rsp_valid = 0, rsp_y = 0, rsp_carry = 0, rsp_id = 0.
  - busy = 0, req_ready = 0 during the reset cycle.
  - In-flight transaction is discarded.
  - Counters and prev_y = 0.
- Opcodes: all 16 passed through unmodified; the block does not interpret them.
- rr_ptr wraps from NREQ-1 to 0.
- Ties are impossible: the grant is a single index.

Optional Feature:
- Macro: ALU16_SCHED_STATS_EN.
- Defined:
  - In EXEC, toggle_count += popcount16(yout ^ prev_y), then prev_y <= yout; prev_y resets to 0.
  - op_count += 1 on each RESP->IDLE handshake.
  - Both counters saturate at 32'hFFFFFFFF.
  - stats_clr zeroes both counters and prev_y next cycle and takes priority over same-cycle increments.
- Undefined: counter and prev_y logic absent; toggle_count and op_count = 0; stats_clr unused.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=0, rsp_valid=0, busy=0, rsp_y=0.
- Single request: requester 2, a=16'h1234, b=16'h00FF, op=4'd0, rsp_ready=1 -> rsp_valid at accept+2, rsp_id=2, rsp_y/rsp_carry equal a bench-side alu16_cla instance fed the same values.
- All 4 requesters held valid for 12 ops -> grant order 0,1,2,3,0,1,2,3,...; no requester granted twice before the others are served.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_y/rsp_id/rsp_carry stable, req_ready=0 throughout; one cycle after rsp_ready=1, rsp_valid=0 and the next grant appears in IDLE.
- Reset asserted in EXEC and again in RESP -> next cycle rsp_valid=0, busy=0, rr_ptr=0 (requesters 0..3 valid => requester 0 granted first).
- With ALU16_SCHED_STATS_EN: 1000 random ops, bench replicates popcount16 -> toggle_count and op_count=1000 match; stats_clr pulse -> both read 0 next cycle.
